// File: rtl/timer_pkg.sv
// Shared definitions for the timer family (elapsed timer, countdown timer).
// Holds the controller state encoding and the default prescaler terminal count.
package timer_pkg;

  // Clocks per tick: 2 Hz at a 104 MHz system clock.
  localparam logic [25:0] DEFAULT_COUNTER_HI = 26'd52_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUNNING   = 2'd1,
    PAUSED    = 2'd2,
    SATURATED = 2'd3
  } timer_state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts enabled cycles 0..COUNTER_HI-1 and flags the wrap cycle.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   enable    - advance the count this cycle; when low the count is frozen
//   clear     - synchronous return to 0 (wins over enable)
//   tick_c    - combinational: high in the enabled cycle whose edge wraps the count
module tick_gen
  import timer_pkg::*;
#(
  parameter int unsigned COUNTER_HI = 32'(DEFAULT_COUNTER_HI)
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (COUNTER_HI > 1) ? $clog2(COUNTER_HI) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNTER_HI - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // With COUNTER_HI=1 the count sits at 0 and every enabled cycle ticks.
  assign tick_c = enable && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/elapsed_timer.sv
// Stopwatch-style elapsed tick counter with pause/resume, lap capture and
// saturation at the top of the count range.
// Ports:
//   clk_104mhz, reset - system clock, asynchronous active-high reset
//   start, stop, resume, clear, lap - single-cycle command pulses (held = repeated)
//   elapsed    - ticks counted since the last start
//   lap_value  - elapsed value captured by the last accepted lap
//   lap_valid  - one-cycle pulse following an accepted lap
//   running    - controller is in RUNNING
//   saturated  - controller is in SATURATED
module elapsed_timer
  import timer_pkg::*;
#(
  parameter logic [25:0] COUNTER_HI = DEFAULT_COUNTER_HI,
  parameter int unsigned WIDTH      = 8
) (
  input  logic             clk_104mhz,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             resume,
  input  logic             clear,
  input  logic             lap,
  output logic [WIDTH-1:0] elapsed,
  output logic [WIDTH-1:0] lap_value,
  output logic             lap_valid,
  output logic             running,
  output logic             saturated
);

  localparam logic [WIDTH-1:0] MAX_COUNT = '1;

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] elapsed_q, elapsed_d;
  logic [WIDTH-1:0] lap_value_q, lap_value_d;
  logic             lap_valid_q, lap_valid_d;
  logic             running_q, running_d;
  logic             saturated_q, saturated_d;

  logic presc_en_c;
  logic presc_clr_c;
  logic tick_c;

  // The prescaler advances in every RUNNING cycle, including the one in which
  // stop is taken, so a pause freezes it one count past the stop edge.
  assign presc_clr_c = clear || start;
  assign presc_en_c  = (state_q == RUNNING) && !presc_clr_c;

  tick_gen #(
    .COUNTER_HI(32'(COUNTER_HI))
  ) u_tick_gen (
    .clk    (clk_104mhz),
    .rst    (reset),
    .enable (presc_en_c),
    .clear  (presc_clr_c),
    .tick_c (tick_c)
  );

  // Next-state, count and lap logic.
  always_comb begin
    state_d     = state_q;
    elapsed_d   = elapsed_q;
    lap_value_d = lap_value_q;
    lap_valid_d = 1'b0;

    if (clear) begin
      state_d   = IDLE;
      elapsed_d = '0;
    end else if (start) begin
      state_d   = RUNNING;
      elapsed_d = '0;
    end else begin
      unique case (state_q)
        RUNNING: begin
          // Reaching the top value saturates even if stop arrives on the same edge.
          if (tick_c && (elapsed_q == MAX_COUNT - WIDTH'(1))) begin
            elapsed_d = MAX_COUNT;
            state_d   = SATURATED;
          end else begin
            if (tick_c) begin
              elapsed_d = elapsed_q + WIDTH'(1);
            end
            if (stop) begin
              state_d = PAUSED;
            end
          end
        end
        PAUSED: begin
          if (resume) begin
            state_d = RUNNING;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end

    // Lap samples the count as it stood before this edge's update.
    if (lap && !clear && (state_q != IDLE)) begin
      lap_value_d = elapsed_q;
      lap_valid_d = 1'b1;
    end

    running_d   = (state_d == RUNNING);
    saturated_d = (state_d == SATURATED);
  end

  always_ff @(posedge clk_104mhz or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      elapsed_q   <= '0;
      lap_value_q <= '0;
      lap_valid_q <= 1'b0;
      running_q   <= 1'b0;
      saturated_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      elapsed_q   <= elapsed_d;
      lap_value_q <= lap_value_d;
      lap_valid_q <= lap_valid_d;
      running_q   <= running_d;
      saturated_q <= saturated_d;
    end
  end

  assign elapsed   = elapsed_q;
  assign lap_value = lap_value_q;
  assign lap_valid = lap_valid_q;
  assign running   = running_q;
  assign saturated = saturated_q;

endmodule

// File: doc/elapsed_timer.md
ELAPSED_TIMER -- requirements
Module: elapsed_timer

Interface
REQ-001 SHALL have parameter COUNTER_HI, default 26'd52_000_000, meaning clocks per tick (2 Hz at 104 MHz).
REQ-002 SHALL have parameter WIDTH, default 8, meaning bit width of the elapsed count.
REQ-003 clk_104mhz  input  1  system clock; one clock only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  pulse: zero count and prescaler, begin counting.
REQ-006 stop  input  1  pulse: pause counting, hold count and prescaler.
REQ-007 resume  input  1  pulse: continue from the paused count and prescaler.
REQ-008 clear  input  1  pulse: zero everything, go idle.
REQ-009 lap  input  1  pulse: capture the current count into lap_value.
REQ-010 elapsed  output  WIDTH  current tick count.
REQ-011 lap_value  output  WIDTH  last captured count.
REQ-012 lap_valid  output  1  one-cycle pulse, the cycle after a lap capture.
REQ-013 running  output  1  high in RUNNING state only.
REQ-014 saturated  output  1  high in SATURATED state only.

Function
REQ-015 SHALL implement states IDLE, RUNNING, PAUSED, SATURATED; all outputs registered.
REQ-016 Input priority in the same cycle SHALL be clear > start > stop > resume > lap; lap is evaluated independently and uses the pre-update elapsed value.
REQ-017 clear (any state) -> IDLE, elapsed=0, prescaler=0; lap_value is retained.
REQ-018 start (any state) -> RUNNING, elapsed=0, prescaler=0.
REQ-019 stop in RUNNING -> PAUSED, prescaler and elapsed frozen; ignored in other states.
REQ-020 resume in PAUSED -> RUNNING, prescaler continues from frozen value; ignored in other states.
REQ-021 In RUNNING, prescaler SHALL count 0..COUNTER_HI-1 and wrap; elapsed SHALL increment on the wrap edge, so start at edge 0 gives elapsed=1 after edge COUNTER_HI.
REQ-022 An increment reaching 2^WIDTH-1 SHALL enter SATURATED on the same edge; elapsed then holds 2^WIDTH-1 and never wraps.
REQ-023 In SATURATED, stop and resume SHALL be ignored; only start or clear leave it.
REQ-024 lap in RUNNING, PAUSED or SATURATED SHALL load lap_value with elapsed and pulse lap_valid for exactly one cycle; lap in IDLE or with clear asserted SHALL be ignored.
REQ-025 Held (multi-cycle) inputs SHALL act as repeated pulses; no edge detection inside the block.
REQ-026 COUNTER_HI=1 SHALL increment every RUNNING cycle.

Reset
REQ-027 reset SHALL asynchronously force IDLE, elapsed=0, lap_value=0, lap_valid=0, running=0, saturated=0, prescaler=0.
REQ-028 Reset asserted mid-count SHALL discard all progress; after release, the block waits in IDLE for start.

Structure
REQ-029 State enum (IDLE, RUNNING, PAUSED, SATURATED) and the default COUNTER_HI constant SHALL live in a shared package timer_pkg.
REQ-030 The prescaler SHALL be a sub-module tick_gen (enable, clear, tick output) that is also reusable by the countdown timer.

Verification (COUNTER_HI=4, WIDTH=4)
REQ-031 reset, start at cycle 0 -> elapsed=1 at cycle 4, 2 at cycle 8; running=1 throughout.
REQ-032 start, stop at cycle 6, resume at cycle 20 -> elapsed holds 1 during the pause; elapsed=2 at cycle 22 (prescaler resumes at 2).
REQ-033 start, run 60 cycles -> elapsed=15 at cycle 60, saturated=1, running=0; elapsed stays 15 and stop/resume are ignored.
REQ-034 lap at elapsed=3 -> lap_value=3 and a one-cycle lap_valid pulse; lap in IDLE -> no pulse.
REQ-035 clear+start+lap in the same cycle while RUNNING -> IDLE, elapsed=0, no lap_valid.
REQ-036 reset asserted asynchronously mid-cycle at elapsed=5 -> all outputs 0 immediately; nothing counts until start.
